// File: rtl/carry_skip_adder.sv
// rtl/carry_skip_adder.sv - registered carry-skip adder, {cout,sum} = a + b + cin
// Optional signed-overflow output ovf enabled by defining CARRY_SKIP_OVF_EN.

module carry_skip_adder #(
  parameter int WIDTH = 4,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef CARRY_SKIP_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             carry;
  logic             blk_cin;
  logic             blk_p;
  logic             rc;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

`ifdef CARRY_SKIP_OVF_EN
  logic             c_msb;
  logic             ovf_d, ovf_q;
`endif

  // Bits ripple inside a block; the block carry-out takes the bypass when every bit propagates.
  always_comb begin
    p        = a ^ b;
    g        = a & b;
    res_sum  = '0;
    carry    = cin;
    blk_cin  = cin;
    blk_p    = 1'b1;
    rc       = cin;
`ifdef CARRY_SKIP_OVF_EN
    c_msb    = 1'b0;
`endif
    for (int i = 0; i < WIDTH; i++) begin
      if (i % BLOCK == 0) begin
        blk_cin = carry;
        rc      = carry;
        blk_p   = 1'b1;
      end
      res_sum[i] = p[i] ^ rc;
`ifdef CARRY_SKIP_OVF_EN
      if (i == WIDTH - 1) c_msb = rc;
`endif
      rc    = g[i] | (p[i] & rc);
      blk_p = blk_p & p[i];
      // The last block may be short when WIDTH is not a multiple of BLOCK.
      if ((i % BLOCK == BLOCK - 1) || (i == WIDTH - 1)) begin
        carry = blk_p ? blk_cin : rc;
      end
    end
    res_cout = carry;
  end

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
`ifdef CARRY_SKIP_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (in_valid) begin
      sum_d  = res_sum;
      cout_d = res_cout;
`ifdef CARRY_SKIP_OVF_EN
      ovf_d  = c_msb ^ res_cout;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef CARRY_SKIP_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef CARRY_SKIP_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
`ifdef CARRY_SKIP_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_carry_skip_adder.sv
// tb/tb_carry_skip_adder.sv - directed and sweep bench for carry_skip_adder
// Nine instances (WIDTH 4/8/16 x BLOCK 4/1/3) share one operand stream.

module tb_carry_skip_adder;

  localparam int NDUT = 9;
  localparam int NW [NDUT] = '{4, 4, 4, 8, 8, 8, 16, 16, 16};
  localparam int NB [NDUT] = '{4, 1, 3, 4, 1, 3, 4, 1, 3};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;

  logic [15:0] sum_o  [NDUT];
  logic        cout_o [NDUT];
  logic        ov_o   [NDUT];
  logic        ovf_o  [NDUT];

  logic [16:0] exp_full [NDUT];
  logic        exp_ov   [NDUT];
  logic        exp_ovf  [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int W = NW[k];
    localparam int B = NB[k];
    logic [W-1:0] s;
    carry_skip_adder #(.WIDTH(W), .BLOCK(B)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a[W-1:0]),
      .b         (b[W-1:0]),
      .cin       (cin),
      .sum       (s),
      .cout      (cout_o[k]),
      .out_valid (ov_o[k])
`ifdef CARRY_SKIP_OVF_EN
      ,
      .ovf       (ovf_o[k])
`endif
    );
    assign sum_o[k] = 16'(s);
`ifndef CARRY_SKIP_OVF_EN
    assign ovf_o[k] = 1'b0;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input int w, input logic [15:0] ta,
                                        input logic [15:0] tb_, input logic tc);
    logic [16:0] mask;
    mask = (17'd1 << w) - 17'd1;
    return ({1'b0, ta} & mask) + ({1'b0, tb_} & mask) + {16'd0, tc};
  endfunction

  // One clock: drive at negedge, update model at posedge, compare every instance 1ns later.
  task automatic cyc(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic tv);
    logic [16:0] full;
    logic [15:0] mask;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; in_valid = tv;
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) begin
        exp_full[k] = '0;
        exp_ov[k]   = 1'b0;
        exp_ovf[k]  = 1'b0;
      end else begin
        exp_ov[k] = tv;
        if (tv) begin
          full        = model(NW[k], ta, tb_, tc);
          exp_full[k] = full;
          exp_ovf[k]  = (ta[NW[k]-1] == tb_[NW[k]-1]) && (full[NW[k]-1] != ta[NW[k]-1]);
        end
      end
    end
    #1;
    for (int k = 0; k < NDUT; k++) begin
      mask = 16'((17'd1 << NW[k]) - 17'd1);
      check($sformatf("u%0d sum", k), 32'(sum_o[k]), 32'(exp_full[k][15:0] & mask));
      check($sformatf("u%0d cout", k), 32'(cout_o[k]), 32'(exp_full[k][NW[k]]));
      check($sformatf("u%0d out_valid", k), 32'(ov_o[k]), 32'(exp_ov[k]));
`ifdef CARRY_SKIP_OVF_EN
      check($sformatf("u%0d ovf", k), 32'(ovf_o[k]), 32'(exp_ovf[k]));
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; cin = 1'b0; a = '0; b = '0;

    // Reset dominates in_valid for two cycles.
    cyc(16'hF, 16'hF, 1'b0, 1'b1);
    check("rst sum", 32'(sum_o[0]), 32'h0);
    check("rst cout", 32'(cout_o[0]), 32'h0);
    check("rst out_valid", 32'(ov_o[0]), 32'h0);
    cyc(16'hF, 16'hF, 1'b0, 1'b1);
    check("rst2 sum", 32'(sum_o[0]), 32'h0);
    check("rst2 out_valid", 32'(ov_o[0]), 32'h0);
    rst_n = 1'b1;
    cyc(16'hF, 16'hF, 1'b0, 1'b1);
    check("post-rst sum", 32'(sum_o[0]), 32'hE);
    check("post-rst cout", 32'(cout_o[0]), 32'h1);
    check("post-rst out_valid", 32'(ov_o[0]), 32'h1);

    cyc(16'b0010, 16'b0100, 1'b0, 1'b1);
    check("basic sum", 32'(sum_o[0]), 32'h6);
    check("basic cout", 32'(cout_o[0]), 32'h0);
    cyc(16'b0001, 16'b0010, 1'b1, 1'b1);
    check("cin sum", 32'(sum_o[0]), 32'h4);
    check("cin cout", 32'(cout_o[0]), 32'h0);
    cyc(16'b1111, 16'b1110, 1'b1, 1'b1);
    check("cout1 sum", 32'(sum_o[0]), 32'hE);
    check("cout1 cout", 32'(cout_o[0]), 32'h1);
    cyc(16'b1110, 16'b1110, 1'b1, 1'b1);
    check("cout2 sum", 32'(sum_o[0]), 32'hD);
    check("cout2 cout", 32'(cout_o[0]), 32'h1);

    // Full skip chain on the 8-bit, 4-bit-block instance, then hold.
    cyc(16'h00FF, 16'h0000, 1'b1, 1'b1);
    check("skip8 sum", 32'(sum_o[3]), 32'h00);
    check("skip8 cout", 32'(cout_o[3]), 32'h1);
    check("skip16 sum", 32'(sum_o[6]), 32'h0100);
    cyc(16'h0012, 16'h0034, 1'b0, 1'b0);
    check("hold sum", 32'(sum_o[3]), 32'h00);
    check("hold cout", 32'(cout_o[3]), 32'h1);
    check("hold out_valid", 32'(ov_o[3]), 32'h0);

    cyc(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    check("max16 sum", 32'(sum_o[7]), 32'hFFFF);
    check("max16 cout", 32'(cout_o[7]), 32'h1);
    cyc(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    check("skipall16 sum", 32'(sum_o[8]), 32'h0000);
    check("skipall16 cout", 32'(cout_o[8]), 32'h1);

`ifdef CARRY_SKIP_OVF_EN
    cyc(16'b0111, 16'b0001, 1'b0, 1'b1);
    check("ovf flag", 32'(ovf_o[0]), 32'h1);
    check("ovf sum", 32'(sum_o[0]), 32'h8);
`endif

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          cyc(16'(x), 16'(y), 1'(c), 1'b1);

    for (int i = 0; i < 300; i++)
      cyc(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));

    // Reset mid-stream drops the pending result.
    cyc(16'h1234, 16'h4321, 1'b0, 1'b1);
    rst_n = 1'b0;
    cyc(16'h1111, 16'h2222, 1'b0, 1'b1);
    check("midrst sum", 32'(sum_o[6]), 32'h0);
    check("midrst out_valid", 32'(ov_o[6]), 32'h0);
    rst_n = 1'b1;
    cyc(16'h1111, 16'h2222, 1'b1, 1'b1);
    check("after midrst sum", 32'(sum_o[6]), 32'h3334);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
